// File: rtl/seq_ctrl.sv
// seq_ctrl: multi-cycle control FSM for a small MIPS-style datapath.
// Each instruction runs FETCH -> DECODE -> class-specific states -> FETCH.
// All control outputs are registered and loaded from the next state, so a
// state's outputs appear in the same cycle that the state becomes current.
// The one exception is pc_write in BRANCH, which also follows the live zero flag.
// Reset clears the output registers asynchronously, so write strobes fall
// as soon as rst_n goes low, without waiting for a clock edge.
module seq_ctrl #(
  parameter int ILLEGAL_HALT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       signed_less,
  input  logic       positive,
  output logic [1:0] alu_ctl,
  output logic       ext_op,
  output logic [2:0] reg_src,
  output logic [1:0] npc_sel,
  output logic [1:0] reg_dst,
  output logic       alu_src,
  output logic       mem_write,
  output logic       mem_op,
  output logic       reg_write,
  output logic       rgs_ins_write,
  output logic       pc_write,
  output logic [3:0] state_o,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_ALUWB  = 4'd7,
    S_OVWB   = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_HALT   = 4'd15
  } state_e;

  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_SLT, I_SRA, I_ORI, I_LUI, I_ADDI,
    I_LW, I_SW, I_BEQ, I_J, I_JAL, I_JR, I_ILL
  } instr_e;

  typedef struct packed {
    logic [1:0] alu_ctl;
    logic       ext_op;
    logic [2:0] reg_src;
    logic [1:0] npc_sel;
    logic [1:0] reg_dst;
    logic       alu_src;
    logic       mem_write;
    logic       mem_op;
    logic       reg_write;
    logic       rgs_ins_write;
    logic       pc_write;
    logic       halted;
  } ctl_t;

  // Output values of FETCH; also the reset value of the output registers.
  localparam ctl_t CTL_FETCH = '{alu_ctl: 2'd0, ext_op: 1'b0, reg_src: 3'd0,
                                 npc_sel: 2'd0, reg_dst: 2'd0, alu_src: 1'b0,
                                 mem_write: 1'b0, mem_op: 1'b0, reg_write: 1'b0,
                                 rgs_ins_write: 1'b1, pc_write: 1'b1,
                                 halted: 1'b0};

  localparam logic ILL_TO_HALT = (ILLEGAL_HALT != 0);

  state_e state_q, state_d;
  instr_e instr;
  logic   ov_q, ov_d;
  logic   lt_q, lt_d;
  ctl_t   ctl_q, ctl_d;

  // positive is carried only for port compatibility.
  logic unused_positive;
  assign unused_positive = positive;

  // Classify the held instruction; the instruction register is stable after FETCH.
  always_comb begin
    instr = I_ILL;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100001: instr = I_ADDU;
          6'b100011: instr = I_SUBU;
          6'b101010: instr = I_SLT;
          6'b000011: instr = I_SRA;
          6'b001000: instr = I_JR;
          default:   instr = I_ILL;
        endcase
      end
      6'b001101: instr = I_ORI;
      6'b001111: instr = I_LUI;
      6'b001000: instr = I_ADDI;
      6'b100011: instr = I_LW;
      6'b101011: instr = I_SW;
      6'b000100: instr = I_BEQ;
      6'b000010: instr = I_J;
      6'b000011: instr = I_JAL;
      default:   instr = I_ILL;
    endcase
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (instr)
          I_LW, I_SW:        state_d = S_MEMADR;
          I_BEQ:             state_d = S_BRANCH;
          I_J, I_JAL, I_JR:  state_d = S_JUMP;
          I_ADDU, I_SUBU, I_SLT, I_SRA,
          I_ORI, I_LUI, I_ADDI: state_d = S_EXEC;
          default:           state_d = ILL_TO_HALT ? S_HALT : S_FETCH;
        endcase
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = (instr == I_ADDI) ? S_OVWB : S_FETCH;
      S_OVWB:   state_d = S_FETCH;
      S_MEMADR: state_d = (instr == I_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Flag capture: only EXEC samples the ALU flags, other states hold them.
  always_comb begin
    ov_d = ov_q;
    lt_d = lt_q;
    if (state_q == S_EXEC) begin
      ov_d = (instr == I_ADDI) && overflow;
      lt_d = (instr == I_SLT) && signed_less;
    end
  end

  // Control word for a given state, instruction class and flag values.
  function automatic ctl_t ctl_for(input state_e s, input instr_e k,
                                   input logic ov, input logic lt);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.rgs_ins_write = 1'b1;
        c.pc_write      = 1'b1;
        c.npc_sel       = 2'd0;
      end
      S_EXEC: begin
        case (k)
          I_SUBU, I_SLT: c.alu_ctl = 2'd1;
          I_ORI:  begin c.alu_ctl = 2'd2; c.alu_src = 1'b1; c.ext_op = 1'b0; end
          I_LUI:  begin c.alu_ctl = 2'd3; c.alu_src = 1'b1; c.ext_op = 1'b0; end
          I_ADDI: begin c.alu_ctl = 2'd0; c.alu_src = 1'b1; c.ext_op = 1'b1; end
          default: c.alu_ctl = 2'd0;
        endcase
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = (k == I_ORI || k == I_LUI || k == I_ADDI) ? 2'd1 : 2'd0;
        case (k)
          I_SLT:   c.reg_src = lt ? 3'd3 : 3'd2;
          I_SRA:   c.reg_src = 3'd5;
          default: c.reg_src = 3'd0;
        endcase
      end
      S_OVWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 2'd2;
        c.reg_src   = ov ? 3'd3 : 3'd2;
      end
      S_MEMADR: begin
        c.alu_ctl = 2'd0;
        c.alu_src = 1'b1;
        c.ext_op  = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 2'd1;
        c.reg_src   = 3'd1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.mem_op    = 1'b0;
      end
      S_BRANCH: begin
        c.alu_ctl = 2'd1;
        c.alu_src = 1'b0;
        c.npc_sel = 2'd1;
      end
      S_JUMP: begin
        c.pc_write = 1'b1;
        case (k)
          I_JAL: begin
            c.npc_sel   = 2'd2;
            c.reg_write = 1'b1;
            c.reg_dst   = 2'd3;
            c.reg_src   = 3'd4;
          end
          I_JR:    c.npc_sel = 2'd3;
          default: c.npc_sel = 2'd2;
        endcase
      end
      S_HALT:  c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb ctl_d = ctl_for(state_d, instr, ov_d, lt_d);

  // State, flag and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ov_q    <= 1'b0;
      lt_q    <= 1'b0;
      ctl_q   <= CTL_FETCH;
    end else begin
      state_q <= state_d;
      ov_q    <= ov_d;
      lt_q    <= lt_d;
      ctl_q   <= ctl_d;
    end
  end

  assign alu_ctl       = ctl_q.alu_ctl;
  assign ext_op        = ctl_q.ext_op;
  assign reg_src       = ctl_q.reg_src;
  assign npc_sel       = ctl_q.npc_sel;
  assign reg_dst       = ctl_q.reg_dst;
  assign alu_src       = ctl_q.alu_src;
  assign mem_write     = ctl_q.mem_write;
  assign mem_op        = ctl_q.mem_op;
  assign reg_write     = ctl_q.reg_write;
  assign rgs_ins_write = ctl_q.rgs_ins_write;
  assign pc_write      = ctl_q.pc_write | ((state_q == S_BRANCH) && zero);
  assign halted        = ctl_q.halted;
  assign state_o       = state_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Bench for seq_ctrl: per-instruction expected output traces go into exp_q,
// a negedge monitor pops one entry per cycle and compares the whole output set.
module tb_seq_ctrl;
  localparam int W = 21;

  localparam int K_ADDU = 0, K_SUBU = 1, K_SLT = 2, K_SRA = 3, K_ORI = 4,
                 K_LUI = 5, K_ADDI = 6, K_LW = 7, K_SW = 8, K_BEQ = 9,
                 K_J = 10, K_JAL = 11, K_JR = 12;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] opcode = '0, funct = '0;
  logic zero = 1'b0, overflow = 1'b0, signed_less = 1'b0, positive = 1'b0;
  logic [1:0] alu_ctl, npc_sel, reg_dst;
  logic [2:0] reg_src;
  logic [3:0] state_o;
  logic ext_op, alu_src, mem_write, mem_op, reg_write, rgs_ins_write, pc_write, halted;

  seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .zero(zero), .overflow(overflow), .signed_less(signed_less), .positive(positive),
    .alu_ctl(alu_ctl), .ext_op(ext_op), .reg_src(reg_src), .npc_sel(npc_sel),
    .reg_dst(reg_dst), .alu_src(alu_src), .mem_write(mem_write), .mem_op(mem_op),
    .reg_write(reg_write), .rgs_ins_write(rgs_ins_write), .pc_write(pc_write),
    .state_o(state_o), .halted(halted)
  );

  logic [W-1:0] act_vec;
  assign act_vec = {state_o, halted, alu_ctl, ext_op, reg_src, npc_sel, reg_dst,
                    alu_src, mem_write, mem_op, reg_write, rgs_ins_write, pc_write};

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;
  int cyc_no  = 0;

  // Expected output word for one cycle; halted and rgs_ins_write follow the state.
  function automatic logic [W-1:0] v(input int st, input int alu, input int ext,
                                     input int rsrc, input int npc, input int rdst,
                                     input int asrc, input int mw, input int rw,
                                     input int pcw);
    logic hlt, rgs;
    hlt = (st == 15);
    rgs = (st == 0);
    return {st[3:0], hlt, alu[1:0], ext[0], rsrc[2:0], npc[1:0], rdst[1:0],
            asrc[0], mw[0], 1'b0, rw[0], rgs, pcw[0]};
  endfunction

  // Reference model: the cycle-by-cycle outputs an instruction should produce.
  function automatic int model_instr(input int k, input bit z, input bit ov, input bit lt);
    int n;
    int alu, asrc, ext, rdst, rsrc;
    n = 2;
    exp_q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    exp_q.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    if (k <= K_ADDI) begin
      alu = 0; asrc = 0; ext = 0; rdst = 0; rsrc = 0;
      case (k)
        K_SUBU:  alu = 1;
        K_SLT:   begin alu = 1; rsrc = lt ? 3 : 2; end
        K_SRA:   rsrc = 5;
        K_ORI:   begin alu = 2; asrc = 1; rdst = 1; end
        K_LUI:   begin alu = 3; asrc = 1; rdst = 1; end
        K_ADDI:  begin asrc = 1; ext = 1; rdst = 1; end
        default: alu = 0;
      endcase
      exp_q.push_back(v(2, alu, ext, 0, 0, 0, asrc, 0, 0, 0));
      exp_q.push_back(v(7, 0, 0, rsrc, 0, rdst, 0, 0, 1, 0));
      n += 2;
      if (k == K_ADDI) begin
        exp_q.push_back(v(8, 0, 0, ov ? 3 : 2, 0, 2, 0, 0, 1, 0));
        n++;
      end
    end else if (k == K_LW || k == K_SW) begin
      exp_q.push_back(v(3, 0, 1, 0, 0, 0, 1, 0, 0, 0));
      n++;
      if (k == K_LW) begin
        exp_q.push_back(v(4, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(v(5, 0, 0, 1, 0, 1, 0, 0, 1, 0));
        n += 2;
      end else begin
        exp_q.push_back(v(6, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        n++;
      end
    end else if (k == K_BEQ) begin
      exp_q.push_back(v(9, 1, 0, 0, 1, 0, 0, 0, 0, int'(z)));
      n++;
    end else if (k == K_J) begin
      exp_q.push_back(v(10, 0, 0, 0, 2, 0, 0, 0, 0, 1));
      n++;
    end else if (k == K_JAL) begin
      exp_q.push_back(v(10, 0, 0, 4, 2, 3, 0, 0, 1, 1));
      n++;
    end else begin
      exp_q.push_back(v(10, 0, 0, 0, 3, 0, 0, 0, 0, 1));
      n++;
    end
    return n;
  endfunction

  // Instruction encodings; don't-care fields are randomized.
  task automatic set_instr(input int k);
    funct  = 6'($urandom_range(0, 63));
    opcode = 6'b000000;
    case (k)
      K_ADDU: funct = 6'b100001;
      K_SUBU: funct = 6'b100011;
      K_SLT:  funct = 6'b101010;
      K_SRA:  funct = 6'b000011;
      K_JR:   funct = 6'b001000;
      K_ORI:  opcode = 6'b001101;
      K_LUI:  opcode = 6'b001111;
      K_ADDI: opcode = 6'b001000;
      K_LW:   opcode = 6'b100011;
      K_SW:   opcode = 6'b101011;
      K_BEQ:  opcode = 6'b000100;
      K_J:    opcode = 6'b000010;
      K_JAL:  opcode = 6'b000011;
      default: opcode = 6'b111111;
    endcase
  endtask

  // Driver: called one step after a clock edge that left the DUT in FETCH.
  task automatic run_instr(input int k, input bit z, input bit ov, input bit lt);
    int n;
    set_instr(k);
    zero = z; overflow = ov; signed_less = lt;
    n = model_instr(k, z, ov, lt);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (mon_en && exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      cyc_no++;
      n_tests++;
      if (act_vec !== e) begin
        n_fail++;
        $display("FAIL trace cycle %0d: got %h (state %0d) expected %h (state %0d)",
                 cyc_no, act_vec, act_vec[W-1 -: 4], e, e[W-1 -: 4]);
      end
    end
  end

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    int n;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_mem_write", 32'(mem_write), 32'd0);
    chk("reset_reg_write", 32'(reg_write), 32'd0);
    release_reset();

    // directed instruction mix
    run_instr(K_ADDU, 1'b0, 1'b0, 1'b0);
    run_instr(K_ADDI, 1'b0, 1'b1, 1'b0);
    run_instr(K_ADDI, 1'b0, 1'b0, 1'b0);
    run_instr(K_LW,   1'b0, 1'b0, 1'b0);
    run_instr(K_SW,   1'b0, 1'b0, 1'b0);
    run_instr(K_BEQ,  1'b0, 1'b0, 1'b0);
    run_instr(K_BEQ,  1'b1, 1'b0, 1'b0);
    run_instr(K_JAL,  1'b0, 1'b0, 1'b0);
    run_instr(K_SLT,  1'b0, 1'b0, 1'b1);
    run_instr(K_SLT,  1'b0, 1'b0, 1'b0);
    run_instr(K_SRA,  1'b1, 1'b1, 1'b1);
    run_instr(K_J,    1'b0, 1'b0, 1'b0);
    run_instr(K_JR,   1'b0, 1'b0, 1'b0);

    // random instruction stream with random flags
    for (int i = 0; i < 80; i++) begin
      run_instr($urandom_range(0, 12), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    // reset in the middle of a store: FETCH, DECODE, MEMADR, then stop in MEMWR
    set_instr(K_SW);
    exp_q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    exp_q.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(v(3, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    chk("memwr_state", 32'(state_o), 32'd6);
    chk("memwr_mem_write", 32'(mem_write), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_mem_write", 32'(mem_write), 32'd0);
    chk("async_state", 32'(state_o), 32'd0);
    chk("async_reg_write", 32'(reg_write), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    release_reset();
    run_instr(K_LW, 1'b0, 1'b0, 1'b0);

    // undecoded opcode parks the FSM in HALT
    opcode = 6'b111111;
    funct  = 6'($urandom_range(0, 63));
    exp_q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    exp_q.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 20; i++) exp_q.push_back(v(15, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    n = 22;
    repeat (n) @(posedge clk);
    #1;
    mon_en = 1'b0;
    chk("halt_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("halt_state", 32'(state_o), 32'd15);
    chk("halt_flag", 32'(halted), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("halt_reset_state", 32'(state_o), 32'd0);
    chk("halt_reset_flag", 32'(halted), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
